// File: rtl/mem_master_pkg.sv
// Shared definitions for the RAM initiator: FSM encoding, response error codes
// and the request address helpers.
package mem_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RECOVER = 2'd3
    } mem_state_e;

    localparam logic [1:0] MEM_ERR_OK      = 2'b00;
    localparam logic [1:0] MEM_ERR_ALIGN   = 2'b01;
    localparam logic [1:0] MEM_ERR_EXC     = 2'b10;
    localparam logic [1:0] MEM_ERR_TIMEOUT = 2'b11;

    function automatic logic [31:0] to_word_addr(input logic [31:0] addr, input logic byte_mode);
        if (byte_mode) begin
            return {2'b00, addr[31:2]};
        end else begin
            return addr;
        end
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr, input logic byte_mode);
        return byte_mode && (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_master_wdt.sv
// Wait-state counter for a pending RAM access; flags the first wait edge
// (RAM status still stale) and the last allowed wait edge.
module mem_master_wdt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic cnt_first,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Counter saturates at LAST so a stuck enable can never wrap back to "first".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_first = (cnt_r == '0);
    assign expired   = (cnt_r == LAST);

endmodule

// File: rtl/mem_master.sv
// CPU-side initiator for the single-port word RAM: one request at a time,
// registered strobes, stale-status filtering, timeout and a one-cycle response.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int BYTE_ADDR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_r_addr,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_line,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_r_line,
    input  logic        mem_rrdy,
    input  logic        mem_wrdy,
    input  logic        mem_exc
);

    localparam logic BYTE_MODE = (BYTE_ADDR != 0);

    mem_state_e  state_r, state_s;
    logic        req_ready_r, req_ready_s;
    logic        resp_valid_r, resp_valid_s;
    logic [31:0] resp_rdata_r, resp_rdata_s;
    logic [1:0]  resp_err_r, resp_err_s;
    logic [31:0] mem_r_addr_r, mem_r_addr_s;
    logic [31:0] mem_w_addr_r, mem_w_addr_s;
    logic [31:0] mem_w_line_r, mem_w_line_s;
    logic        mem_read_r, mem_read_s;
    logic        mem_write_r, mem_write_s;
    logic        in_wait_s;
    logic        hit_s;
    logic        cnt_first_s;
    logic        expired_s;

    assign in_wait_s = (state_r == ST_RD_WAIT) || (state_r == ST_WR_WAIT);

    mem_master_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .clr       (!in_wait_s),
        .en        (in_wait_s),
        .cnt_first (cnt_first_s),
        .expired   (expired_s)
    );

    // Next-state and next-output decode for the access FSM.
    always_comb begin
        state_s      = state_r;
        resp_valid_s = 1'b0;
        resp_rdata_s = resp_rdata_r;
        resp_err_s   = resp_err_r;
        mem_r_addr_s = mem_r_addr_r;
        mem_w_addr_s = mem_w_addr_r;
        mem_w_line_s = mem_w_line_r;
        mem_read_s   = mem_read_r;
        mem_write_s  = mem_write_r;
        hit_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
                if (req_valid && req_ready_r) begin
                    mem_r_addr_s = to_word_addr(req_addr, BYTE_MODE);
                    mem_w_addr_s = to_word_addr(req_addr, BYTE_MODE);
                    mem_w_line_s = req_wdata;
                    if (is_misaligned(req_addr, BYTE_MODE)) begin
                        state_s      = ST_RECOVER;
                        resp_valid_s = 1'b1;
                        resp_err_s   = MEM_ERR_ALIGN;
                        resp_rdata_s = 32'd0;
                    end else if (req_we) begin
                        state_s     = ST_WR_WAIT;
                        mem_write_s = 1'b1;
                    end else begin
                        state_s    = ST_RD_WAIT;
                        mem_read_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RD_WAIT, ST_WR_WAIT: begin
                hit_s = (state_r == ST_RD_WAIT) ? mem_rrdy : mem_wrdy;
                // RAM status seen on the first wait edge belongs to the previous access.
                if (cnt_first_s) begin
                    state_s = state_r;
                end else if (hit_s || mem_exc || expired_s) begin
                    state_s      = ST_RECOVER;
                    mem_read_s   = 1'b0;
                    mem_write_s  = 1'b0;
                    resp_valid_s = 1'b1;
                    resp_rdata_s = 32'd0;
                    if (hit_s) begin
                        resp_err_s = MEM_ERR_OK;
                        if (state_r == ST_RD_WAIT) begin
                            resp_rdata_s = mem_r_line;
                        end else begin
                            resp_rdata_s = 32'd0;
                        end
                    end else if (mem_exc) begin
                        resp_err_s = MEM_ERR_EXC;
                    end else begin
                        resp_err_s = MEM_ERR_TIMEOUT;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            ST_RECOVER: begin
                state_s     = ST_IDLE;
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
            end

            default: begin
                state_s     = ST_IDLE;
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
            end
        endcase

        req_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset drops strobes without issuing a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= MEM_ERR_OK;
            mem_r_addr_r <= 32'd0;
            mem_w_addr_r <= 32'd0;
            mem_w_line_r <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
            mem_r_addr_r <= mem_r_addr_s;
            mem_w_addr_r <= mem_w_addr_s;
            mem_w_line_r <= mem_w_line_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_r_addr = mem_r_addr_r;
    assign mem_w_addr = mem_w_addr_r;
    assign mem_w_line = mem_w_line_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: behavioural 1024-word RAM plus a
// request-level reference model predicting error code, data and latency.
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_r_addr, mem_w_addr, mem_w_line;
    logic        mem_read, mem_write;
    logic [31:0] mem_r_line;
    logic        mem_rrdy, mem_wrdy, mem_exc;

    logic [31:0] ram_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        ram_dead;
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_master #(.TIMEOUT(TIMEOUT), .BYTE_ADDR(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_line(mem_w_line),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_r_line(mem_r_line), .mem_rrdy(mem_rrdy), .mem_wrdy(mem_wrdy), .mem_exc(mem_exc)
    );

    // RAM: one-cycle response to each strobed edge, sticky exc until the next good access.
    always @(posedge clk) begin
        if (pre_we) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (rst || ram_dead) begin
            mem_rrdy <= 1'b0; mem_wrdy <= 1'b0; mem_exc <= 1'b0;
        end else if (mem_read) begin
            mem_wrdy <= 1'b0;
            if (mem_r_addr < 32'd1024) begin
                mem_r_line <= ram_mem[mem_r_addr[9:0]]; mem_rrdy <= 1'b1; mem_exc <= 1'b0;
            end else begin
                mem_rrdy <= 1'b0; mem_exc <= 1'b1;
            end
        end else if (mem_write) begin
            mem_rrdy <= 1'b0;
            if (mem_w_addr < 32'd1024) begin
                ram_mem[mem_w_addr[9:0]] <= mem_w_line; mem_wrdy <= 1'b1; mem_exc <= 1'b0;
            end else begin
                mem_wrdy <= 1'b0; mem_exc <= 1'b1;
            end
        end else begin
            mem_rrdy <= 1'b0; mem_wrdy <= 1'b0;
        end
    end

    task automatic preload(input logic [9:0] word, input logic [31:0] data);
        pre_we = 1'b1; pre_addr = word; pre_data = data;
        ref_mem[word] = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One request with expectations from the reference model; returns at a negedge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] word, exp_rdata, got_rdata, got_addr, got_line;
        logic [1:0]  exp_err, got_err;
        int          exp_lat, lat, n, strb, wrong;
        logic        got, strb_at_resp, misal;
        word = addr >> 2;
        misal = (addr[1:0] != 2'b00);
        exp_rdata = 32'd0;
        if (misal) begin
            exp_err = MEM_ERR_ALIGN; exp_lat = 1;
        end else if (ram_dead) begin
            exp_err = MEM_ERR_TIMEOUT; exp_lat = TIMEOUT + 1;
        end else if (word >= 32'd1024) begin
            exp_err = MEM_ERR_EXC; exp_lat = 3;
        end else begin
            exp_err = MEM_ERR_OK; exp_lat = 3;
            if (we) ref_mem[word[9:0]] = wdata;
            else exp_rdata = ref_mem[word[9:0]];
        end

        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
            return;
        end
        passes++;

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0; lat = 0; strb = 0; wrong = 0; strb_at_resp = 1'b0;
        got_addr = 32'd0; got_line = 32'd0; got_rdata = 32'd0; got_err = 2'b00;
        for (int k = 1; k <= TIMEOUT + 8 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                got_addr = we ? mem_w_addr : mem_r_addr;
                got_line = mem_w_line;
            end
            if (resp_valid === 1'b1) begin
                got = 1'b1; lat = k; got_rdata = resp_rdata; got_err = resp_err;
                strb_at_resp = mem_read | mem_write;
            end else begin
                if (we ? mem_write : mem_read) strb++;
                if (we ? mem_read : mem_write) wrong++;
            end
        end

        checks++;
        if (!got) begin
            $display("FAIL resp_seen addr=%h: no resp_valid within %0d cycles, required one", addr, TIMEOUT + 8);
            return;
        end
        passes++;
        checks++; if (lat !== exp_lat) $display("FAIL latency addr=%h: got %0d required %0d", addr, lat, exp_lat); else passes++;
        checks++; if (got_err !== exp_err) $display("FAIL resp_err addr=%h: got %b required %b", addr, got_err, exp_err); else passes++;
        checks++; if (got_rdata !== exp_rdata) $display("FAIL resp_rdata addr=%h: got %h required %h", addr, got_rdata, exp_rdata); else passes++;
        checks++; if (strb !== exp_lat - 1) $display("FAIL strobe_cycles addr=%h: got %0d required %0d", addr, strb, exp_lat - 1); else passes++;
        checks++; if (wrong !== 0) $display("FAIL wrong_strobe addr=%h: got %0d required 0", addr, wrong); else passes++;
        checks++; if (strb_at_resp !== 1'b0) $display("FAIL strobe_at_resp addr=%h: got %b required 0", addr, strb_at_resp); else passes++;
        if (!misal) begin
            checks++; if (got_addr !== word) $display("FAIL mem_addr addr=%h: got %h required %h", addr, got_addr, word); else passes++;
            if (we) begin
                checks++; if (got_line !== wdata) $display("FAIL mem_w_line addr=%h: got %h required %h", addr, got_line, wdata); else passes++;
            end
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) $display("FAIL resp_pulse addr=%h: resp_valid=%b required 0", addr, resp_valid); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL ready_after addr=%h: req_ready=%b required 1", addr, req_ready); else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b1000 ||
            {resp_rdata, mem_r_addr, mem_w_addr, mem_w_line} !== 128'd0 || resp_err !== 2'b00)
            $display("FAIL reset_state: ready=%b valid=%b rd=%b wr=%b err=%b required 1/0/0/0/00 and zero buses",
                     req_ready, resp_valid, mem_read, mem_write, resp_err);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_req(1'b0, 32'h10, 32'd0);
        do_req(1'b1, 32'h20, 32'h12345678);
        do_req(1'b0, 32'h20, 32'd0);
        do_req(1'b0, 32'h13, 32'd0);
        do_req(1'b1, 32'h22, 32'hCAFEF00D);
        do_req(1'b0, 32'h1000, 32'd0);
        do_req(1'b0, 32'h0, 32'd0);
        do_req(1'b1, 32'h2000, 32'h55AA55AA);
        do_req(1'b1, 32'h4, 32'hA5A5A5A5);
    endtask

    task automatic test_timeout();
        ram_dead = 1'b1;
        do_req(1'b0, 32'h10, 32'd0);
        do_req(1'b1, 32'h30, 32'h0BADF00D);
        ram_dead = 1'b0;
        do_req(1'b0, 32'h30, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int sel;
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            addr = {20'd0, 6'($urandom_range(0, 63)), 2'b00};
            if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
            else if (sel == 1) addr = {18'd0, 1'b1, 11'($urandom_range(0, 2047)), 2'b00};
            do_req(1'($urandom_range(0, 1)), addr, $urandom);
        end
    endtask

    task automatic test_reset_mid_access();
        int n, seen;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) $display("FAIL rd_wait_strobe: mem_read=%b required 1", mem_read); else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, resp_valid, req_ready} !== 4'b0001)
            $display("FAIL reset_mid_access: rd=%b wr=%b valid=%b ready=%b required 0/0/0/1",
                     mem_read, mem_write, resp_valid, req_ready);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL post_reset_quiet: %0d bad cycles required 0", seen); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        ram_dead = 1'b0; pre_we = 1'b0; pre_addr = 10'd0; pre_data = 32'd0;
        test_reset();
        for (int w = 0; w < 64; w++) preload(10'(w), $urandom);
        preload(10'd4, 32'hDEADBEEF);
        test_directed();
        test_timeout();
        test_random();
        do_req(1'b0, 32'h10, 32'd0);
        test_reset_mid_access();
        do_req(1'b0, 32'h10, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
